alu_arbiter: RTL and testbench

- Shares the single combinational 32-bit ALU between two requesters (e.g. the main control path and a secondary address/branch path).
- Round-robin grant; registers the winner's opcode and operands onto the ALU inputs; holds them for an op-dependent number of cycles to give MUL/DIV paths time to settle.
- Returns the captured result to the winner with a one-cycle valid pulse.

---
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between two requesters. A round-robin
// arbiter picks a winner in IDLE or RESP. The winner's opcode and operands
// are registered onto the ALU inputs and held for an op-dependent number of
// EXEC cycles. The ALU result is then captured and returned to the winner
// with a one-cycle valid pulse.
//
// Ports:
//   clock, clear_n            clock, asynchronous active-low reset
//   req0/op0/a0/b0            requester 0 request, opcode, operands
//   gnt0                      one-cycle pulse, request 0 accepted
//   rsp_valid0/rsp_data0      one-cycle response pulse and held result
//   req1 ... rsp_data1        same for requester 1
//   rsp_err                   divide-by-zero flag, qualified by rsp_valid0/1
//   alu_operation/alu_a/alu_b registered opcode and operands to the ALU
//   alu_c                     ALU result
//   busy                      high while an operation is executing
module alu_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [3:0]  MUL_OP     = 4'b1111,
  parameter logic [3:0]  DIV_OP     = 4'b1110,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             req0,
  input  logic [3:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  output logic             rsp_valid0,
  output logic [WIDTH-1:0] rsp_data0,
  input  logic             req1,
  input  logic [3:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic             rsp_valid1,
  output logic [WIDTH-1:0] rsp_data1,
  output logic             rsp_err,
  output logic [3:0]       alu_operation,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_c,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state;
  state_t             state_next;
  logic               prio;       // requester that wins when both ask
  logic               winner;     // requester owning the current operation
  logic               div_zero;   // current operation is a divide by zero
  logic [3:0]         count;      // EXEC cycles remaining, including this one

  logic               take;
  logic               pick;
  logic [3:0]         pick_op;
  logic [WIDTH-1:0]   pick_a;
  logic [WIDTH-1:0]   pick_b;
  logic               pick_div_zero;
  logic [3:0]         load_count;

  // Arbitration: requests only count outside EXEC. A lone requester always
  // wins, a tie goes to whoever was not granted last. A divide by zero
  // gets a single EXEC cycle because its result is forced anyway.
  always_comb begin
    take          = (state != EXEC) && (req0 || req1);
    pick          = (req0 && req1) ? prio : req1;
    pick_op       = pick ? op1 : op0;
    pick_a        = pick ? a1 : a0;
    pick_b        = pick ? b1 : b0;
    pick_div_zero = (pick_op == DIV_OP) && (pick_b == '0);
    load_count    = 4'd1;
    if (pick_op == MUL_OP) begin
      load_count = 4'(MUL_CYCLES);
    end else if ((pick_op == DIV_OP) && !pick_div_zero) begin
      load_count = 4'(DIV_CYCLES);
    end
  end

  // Next-state logic. RESP behaves like IDLE for arbitration, so a waiting
  // request goes straight back to EXEC with no idle cycle in between.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, RESP: state_next = take ? EXEC : IDLE;
      EXEC:       if (count == 4'd1) state_next = RESP;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath. Grant and response strobes default low each cycle so they are
  // single-cycle pulses. ALU input registers only change on a grant. Each
  // requester's result register only changes on its own capture.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      prio          <= 1'b0;
      winner        <= 1'b0;
      div_zero      <= 1'b0;
      count         <= 4'd0;
      alu_operation <= 4'd0;
      alu_a         <= '0;
      alu_b         <= '0;
      gnt0          <= 1'b0;
      gnt1          <= 1'b0;
      rsp_valid0    <= 1'b0;
      rsp_valid1    <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_data0     <= '0;
      rsp_data1     <= '0;
    end else begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_err    <= 1'b0;
      if (take) begin
        alu_operation <= pick_op;
        alu_a         <= pick_a;
        alu_b         <= pick_b;
        winner        <= pick;
        prio          <= ~pick;
        div_zero      <= pick_div_zero;
        count         <= load_count;
        gnt0          <= ~pick;
        gnt1          <= pick;
      end else if (state == EXEC) begin
        count <= count - 4'd1;
        if (count == 4'd1) begin
          rsp_err <= div_zero;
          if (winner) begin
            rsp_valid1 <= 1'b1;
            rsp_data1  <= div_zero ? '0 : alu_c;
          end else begin
            rsp_valid0 <= 1'b1;
            rsp_data0  <= div_zero ? '0 : alu_c;
          end
        end
      end
    end
  end

  assign busy = (state == EXEC);

  // A zero or oversized cycle count cannot be represented by the 4-bit
  // counter and would stall or wrap.
  cycles_legal: assert property (@(posedge clock)
    (MUL_CYCLES >= 1) && (MUL_CYCLES <= 15) &&
    (DIV_CYCLES >= 1) && (DIV_CYCLES <= 15));

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. Provides a behavioural ALU on alu_c. Drivers
// push the expected result of each issued op into a per-requester queue.
// A negedge monitor pops and compares when a response appears. The monitor
// also follows grant order, latency, busy and ALU-input hold with a small
// transaction-level model.
module tb_alu_arbiter;

  localparam logic [3:0] MUL = 4'b1111;
  localparam logic [3:0] DIV = 4'b1110;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        req0, req1;
  logic [3:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, busy;
  logic [31:0] rsp_data0, rsp_data1, alu_a, alu_b, alu_c;
  logic [3:0]  alu_operation;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model state
  int          cyc;
  int          rsp_cyc;
  bit          inflight;
  bit          cur_id;
  bit          last_w;
  bit          open_prev;
  logic [31:0] last_data [2];
  logic [3:0]  exp_op;
  logic [31:0] exp_a, exp_b;
  logic        s_req0, s_req1;
  logic [3:0]  s_op0, s_op1;
  logic [31:0] s_a0, s_b0, s_a1, s_b1;

  always #5 clock = ~clock;

  alu_arbiter dut (
    .clock(clock), .clear_n(clear_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .gnt0(gnt0), .rsp_valid0(rsp_valid0), .rsp_data0(rsp_data0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt1(gnt1), .rsp_valid1(rsp_valid1), .rsp_data1(rsp_data1),
    .rsp_err(rsp_err), .alu_operation(alu_operation),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .busy(busy)
  );

  // Behavioural ALU. A divide by zero returns a junk pattern so the
  // arbiter's forced-zero result is actually exercised.
  function automatic logic [31:0] alu_fn(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      DIV:     return (b == 32'd0) ? 32'hDEAD_BEEF : a / b;
      MUL:     return a * b;
      default: return a;
    endcase
  endfunction

  assign alu_c = alu_fn(alu_operation, alu_a, alu_b);

  function automatic int exec_cycles(input logic [3:0] op, input logic [31:0] b);
    if (op == MUL) return 4;
    if (op == DIV && b != 32'd0) return 8;
    return 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] expected);
    checks++;
    if (got !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, expected, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_gnt0"}, gnt0, 0);
    checkOutput({tag, "_gnt1"}, gnt1, 0);
    checkOutput({tag, "_rsp_valid0"}, rsp_valid0, 0);
    checkOutput({tag, "_rsp_valid1"}, rsp_valid1, 0);
    checkOutput({tag, "_rsp_err"}, rsp_err, 0);
    checkOutput({tag, "_rsp_data0"}, rsp_data0, 0);
    checkOutput({tag, "_rsp_data1"}, rsp_data1, 0);
    checkOutput({tag, "_alu_operation"}, {28'd0, alu_operation}, 0);
    checkOutput({tag, "_alu_a"}, alu_a, 0);
    checkOutput({tag, "_alu_b"}, alu_b, 0);
  endtask

  task automatic model_reset();
    cyc          = 0;
    rsp_cyc      = 0;
    inflight     = 1'b0;
    cur_id       = 1'b0;
    last_w       = 1'b1;
    open_prev    = 1'b1;
    last_data[0] = 32'd0;
    last_data[1] = 32'd0;
    exp_op       = 4'd0;
    exp_a        = 32'd0;
    exp_b        = 32'd0;
    q0.delete();
    q1.delete();
  endtask

  // Raise a request, push its expected response, wait for the grant.
  // With keep set the request stays high so the caller can chain another op.
  task automatic applyStimulus(input int id, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input bit keep);
    exp_t e;
    bit   got;
    e.err  = (op == DIV) && (b == 32'd0);
    e.data = e.err ? 32'd0 : alu_fn(op, a, b);
    if (id == 0) begin
      op0 = op; a0 = a; b0 = b; req0 = 1'b1; q0.push_back(e);
    end else begin
      op1 = op; a1 = a; b1 = b; req1 = 1'b1; q1.push_back(e);
    end
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clock);
      got = (id == 0) ? gnt0 : gnt1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout%0d: got no gnt expected gnt within 300 cycles", id);
    end
    if (!keep || !got) begin
      if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    end
  endtask

  task automatic randomTraffic(input int id, input int n);
    bit          keep;
    bit          prev_keep;
    int          sel;
    logic [3:0]  op;
    logic [31:0] b;
    prev_keep = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!prev_keep) repeat ($urandom_range(0, 3)) @(negedge clock);
      sel = $urandom_range(0, 7);
      op  = (sel == 7) ? MUL : (sel == 6) ? DIV : 4'(sel);
      b   = (op == DIV && $urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      keep = ($urandom_range(0, 1) == 1) && (k < n - 1);
      applyStimulus(id, op, $urandom, b, keep);
      prev_keep = keep;
    end
  endtask

  // Snapshot inputs at the decision edge; they only change at negedges.
  always @(posedge clock) begin
    s_req0 = req0; s_req1 = req1;
    s_op0  = op0;  s_op1  = op1;
    s_a0   = a0;   s_b0   = b0;
    s_a1   = a1;   s_b1   = b1;
  end

  // Monitor and scoreboard.
  always @(negedge clock) begin
    bit   g;
    bit   w;
    bit   exp_rv;
    exp_t e;
    if (mon_en) begin
      cyc++;
      exp_rv = inflight && (cyc == rsp_cyc);
      checkOutput("rsp_valid0", rsp_valid0, exp_rv && !cur_id);
      checkOutput("rsp_valid1", rsp_valid1, exp_rv && cur_id);
      if (rsp_valid0) begin
        if (q0.size() == 0) begin
          checkOutput("rsp0_unexpected", 1, 0);
        end else begin
          e = q0.pop_front();
          checkOutput("rsp_data0", rsp_data0, e.data);
          checkOutput("rsp_err0", rsp_err, e.err);
          last_data[0] = e.data;
        end
      end else begin
        checkOutput("rsp_data0_hold", rsp_data0, last_data[0]);
      end
      if (rsp_valid1) begin
        if (q1.size() == 0) begin
          checkOutput("rsp1_unexpected", 1, 0);
        end else begin
          e = q1.pop_front();
          checkOutput("rsp_data1", rsp_data1, e.data);
          checkOutput("rsp_err1", rsp_err, e.err);
          last_data[1] = e.data;
        end
      end else begin
        checkOutput("rsp_data1_hold", rsp_data1, last_data[1]);
      end

      // Grant expected if the arbiter was free at the last edge and anyone
      // asked; ties go to whoever was not served last.
      g = open_prev && (s_req0 || s_req1);
      w = (s_req0 && s_req1) ? !last_w : s_req1;
      checkOutput("gnt0", gnt0, g && !w);
      checkOutput("gnt1", gnt1, g && w);
      if (g) begin
        last_w   = w;
        cur_id   = w;
        inflight = 1'b1;
        exp_op   = w ? s_op1 : s_op0;
        exp_a    = w ? s_a1 : s_a0;
        exp_b    = w ? s_b1 : s_b0;
        rsp_cyc  = cyc + exec_cycles(exp_op, exp_b);
      end
      checkOutput("busy", busy, inflight && (cyc < rsp_cyc));
      checkOutput("alu_operation", {28'd0, alu_operation}, {28'd0, exp_op});
      checkOutput("alu_a", alu_a, exp_a);
      checkOutput("alu_b", alu_b, exp_b);
      open_prev = !inflight || (cyc >= rsp_cyc);
    end
  end

  initial begin
    req0 = 1'b0; req1 = 1'b0;
    op0 = 4'd0; op1 = 4'd0;
    a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
    clear_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    checkAllZero("reset");
    #1 clear_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    @(negedge clock);

    $display("[TB] single add");
    applyStimulus(0, 4'h0, 32'd5, 32'd7, 1'b0);
    repeat (3) @(negedge clock);

    $display("[TB] simultaneous requests, back-to-back");
    fork
      applyStimulus(0, 4'h1, 32'd9, 32'd4, 1'b0);
      applyStimulus(1, 4'h2, 32'hF0, 32'h3C, 1'b0);
    join
    repeat (3) @(negedge clock);

    $display("[TB] six held grants alternate");
    fork
      for (int i = 0; i < 3; i++) applyStimulus(0, 4'h0, 32'(i), 32'd1, i < 2);
      for (int i = 0; i < 3; i++) applyStimulus(1, 4'h4, 32'(i + 10), 32'd3, i < 2);
    join
    repeat (3) @(negedge clock);

    $display("[TB] multiply with request raised mid-exec");
    fork
      applyStimulus(1, MUL, 32'd6, 32'd7, 1'b0);
      begin
        repeat (2) @(negedge clock);
        applyStimulus(0, 4'h3, 32'd1, 32'd2, 1'b0);
      end
    join
    repeat (4) @(negedge clock);

    $display("[TB] divide by zero, then 100/7");
    applyStimulus(0, DIV, 32'd100, 32'd0, 1'b0);
    repeat (3) @(negedge clock);
    applyStimulus(0, DIV, 32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clock);

    $display("[TB] reset during divide");
    applyStimulus(0, DIV, 32'd100, 32'd7, 1'b0);
    repeat (2) @(negedge clock);
    #1 mon_en = 1'b0;
    clear_n = 1'b0;
    #1 checkAllZero("midreset");
    repeat (2) @(negedge clock);
    #1 clear_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    repeat (12) @(negedge clock);
    fork
      applyStimulus(0, 4'h0, 32'd3, 32'd4, 1'b0);
      applyStimulus(1, 4'h1, 32'd20, 32'd5, 1'b0);
    join
    repeat (3) @(negedge clock);
    applyStimulus(1, 4'h3, 32'h0F, 32'hF0, 1'b0);
    repeat (3) @(negedge clock);

    $display("[TB] random traffic");
    fork
      randomTraffic(0, 30);
      randomTraffic(1, 30);
    join
    repeat (20) @(negedge clock);
    checkOutput("q0_drained", q0.size(), 0);
    checkOutput("q1_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
